icache_ctrl: RTL and testbench

//  Direct-mapped instruction cache with refill sequencer, between the fetch stage and the

---
 rtl/icache_ctrl_pkg.sv | 19 +
 rtl/icache_line_array.sv | 59 +++++
 rtl/icache_ctrl.sv | 139 +++++++++++++
 tb/tb_icache_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// icache_ctrl_pkg : shared sizes and FSM encoding for the instruction cache
// Rev 1.0
// ============================================================================
package icache_ctrl_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int BLOCK_SIZE  = 16;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
// icache_line_array : valid/tag/data storage, one read port, full-line write
// Rev 1.0
// ============================================================================
module icache_line_array
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = WORD_SIZE - OFFSET_BITS - INDEX_BITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [INDEX_BITS-1:0]            rd_index,
  input  logic [OFFSET_BITS-1:0]           rd_offset,
  output logic                             rd_valid,
  output logic [TAG_BITS-1:0]              rd_tag,
  output logic [WORD_SIZE-1:0]             rd_word,
  input  logic                             wr_en,
  input  logic                             wr_valid,
  input  logic [INDEX_BITS-1:0]            wr_index,
  input  logic [TAG_BITS-1:0]              wr_tag,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  wr_block
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tags [LINES];
  logic [WORD_SIZE-1:0] data [LINES][BLOCK_SIZE];

  // Flush has priority over a same-cycle refill, so that line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= wr_valid;
    end
  end

  // Word 0 of the memory block sits in the MSBs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        data[wr_index][i] <= wr_block[WORD_SIZE*(BLOCK_SIZE-i)-1 -: WORD_SIZE];
      end
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = data[rd_index][rd_offset];

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// icache_ctrl : direct-mapped instruction cache with refill sequencer
// Rev 1.0
// ============================================================================
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS  = 3,
  parameter int MEM_LATENCY = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req,
  input  logic [WORD_SIZE-1:0]             cpu_addr,
  output logic [WORD_SIZE-1:0]             cpu_inst,
  output logic                             cpu_valid,
  output logic                             cpu_stall,
  input  logic                             flush,
  output logic [WORD_SIZE-1:0]             mem_ptr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  mem_block,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
);

  localparam int TAG_BITS = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int TAG_LSB  = OFFSET_BITS + INDEX_BITS;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] req_addr;
  logic [CNT_W-1:0]     cnt;
  logic                 flushed;
  logic [WORD_SIZE-1:0] ptr_q;
  logic [31:0]          hit_cnt, miss_cnt;

  logic [WORD_SIZE-1:0] lk_addr;
  logic                 rd_valid;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 hit;
  logic                 fill_done;

  logic                 valid_c, stall_c, hit_ev, miss_ev;
  logic [WORD_SIZE-1:0] inst_c;

  // The latched address owns the array port for the whole miss.
  assign lk_addr   = (state == IDLE) ? cpu_addr : req_addr;
  assign hit       = rd_valid && (rd_tag == lk_addr[WORD_SIZE-1:TAG_LSB]);
  assign fill_done = (state == FILL) && (cnt == '0);

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rd_index  (lk_addr[TAG_LSB-1:OFFSET_BITS]),
    .rd_offset (lk_addr[OFFSET_BITS-1:0]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (fill_done),
    .wr_valid  (!flushed),
    .wr_index  (req_addr[TAG_LSB-1:OFFSET_BITS]),
    .wr_tag    (req_addr[WORD_SIZE-1:TAG_LSB]),
    .wr_block  (mem_block)
  );

  always_comb begin
    state_nxt = state;
    valid_c   = 1'b0;
    stall_c   = 1'b0;
    inst_c    = '0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            valid_c = 1'b1;
            inst_c  = rd_word;
            hit_ev  = 1'b1;
          end else begin
            stall_c   = 1'b1;
            miss_ev   = 1'b1;
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        stall_c = 1'b1;
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        valid_c   = 1'b1;
        inst_c    = rd_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_addr <= '0;
      cnt      <= '0;
      flushed  <= 1'b0;
      ptr_q    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (miss_ev) begin
        req_addr <= cpu_addr;
        cnt      <= CNT_W'(MEM_LATENCY - 1);
        ptr_q    <= {cpu_addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        flushed  <= 1'b0;
      end else if (state == FILL) begin
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
        if (flush)     flushed <= 1'b1;
      end
      if (hit_ev && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_ev && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  // Outputs are forced low while reset is held, even before any edge.
  assign cpu_valid  = rst_n && valid_c;
  assign cpu_stall  = rst_n && stall_c;
  assign cpu_inst   = rst_n ? inst_c : '0;
  assign mem_ptr    = ptr_q;
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_icache_ctrl : table-driven, directed and randomized checks of icache_ctrl
// Rev 1.0
// ============================================================================
module tb_icache_ctrl;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_inst;
  logic         cpu_valid;
  logic         cpu_stall;
  logic         flush;
  logic [31:0]  mem_ptr;
  logic [511:0] mem_block;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks = 0;
  int errors = 0;

  // Reference state: one entry per line, plus expected counters and pointer.
  bit [7:0]    m_valid;
  logic [24:0] m_tag [8];
  logic [31:0] m_hits, m_misses, m_ptr;

  icache_ctrl #(.INDEX_BITS(3), .MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_inst   (cpu_inst),
    .cpu_valid  (cpu_valid),
    .cpu_stall  (cpu_stall),
    .flush      (flush),
    .mem_ptr    (mem_ptr),
    .mem_block  (mem_block),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  always_comb begin
    mem_block = '0;
    for (int i = 0; i < 16; i++) begin
      mem_block[32*(16-i)-1 -: 32] = mem_word(mem_ptr + 32'(i));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[31:7]);
  endfunction

  task automatic model_reset();
    m_valid  = '0;
    m_hits   = '0;
    m_misses = '0;
    m_ptr    = '0;
  endtask

  // fsel: 0 none, 1..LAT flush on that FILL cycle, 9 flush with the request
  task automatic fetch(input logic [31:0] a, input int fsel, input bit exp_hit);
    logic [31:0] blk;
    blk      = {a[31:4], 4'h0};
    cpu_req  = 1'b1;
    cpu_addr = a;
    flush    = (fsel == 9);
    @(negedge clk);
    chk("req_valid", 32'(cpu_valid), 32'(exp_hit));
    chk("req_stall", 32'(cpu_stall), 32'(!exp_hit));
    if (exp_hit) begin
      chk("hit_inst", cpu_inst, mem_word(a));
      chk("hit_ptr", mem_ptr, m_ptr);
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else begin
      if (m_misses != 32'hFFFF_FFFF) m_misses++;
      for (int k = 1; k <= LAT; k++) begin
        @(posedge clk); #1;
        flush    = (fsel == k);
        cpu_addr = $urandom;
        @(negedge clk);
        chk("fill_stall", 32'(cpu_stall), 32'd1);
        chk("fill_valid", 32'(cpu_valid), 32'd0);
        chk("fill_ptr", mem_ptr, blk);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("resp_valid", 32'(cpu_valid), 32'd1);
      chk("resp_stall", 32'(cpu_stall), 32'd0);
      chk("resp_inst", cpu_inst, mem_word(a));
      m_ptr = blk;
    end
    if (fsel != 0) m_valid = '0;
    if (!exp_hit && !(fsel >= 1 && fsel <= LAT)) begin
      m_valid[a[6:4]] = 1'b1;
      m_tag[a[6:4]]   = a[31:7];
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    @(negedge clk);
    chk({tag, "_hits"}, hit_count, m_hits);
    chk({tag, "_misses"}, miss_count, m_misses);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          fsel;
    bit          hit;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{32'h0000_0023, 0, 1'b0, 32'd0, 32'd1};
    vt[1]  = '{32'h0000_002F, 0, 1'b1, 32'd1, 32'd1};
    vt[2]  = '{32'h0000_0005, 0, 1'b0, 32'd1, 32'd2};
    vt[3]  = '{32'h0000_0085, 0, 1'b0, 32'd1, 32'd3};
    vt[4]  = '{32'h0000_0005, 0, 1'b0, 32'd1, 32'd4};
    vt[5]  = '{32'h0000_0040, 2, 1'b0, 32'd1, 32'd5};
    vt[6]  = '{32'h0000_0040, 0, 1'b0, 32'd1, 32'd6};
    vt[7]  = '{32'h0000_0040, 0, 1'b1, 32'd2, 32'd6};
    vt[8]  = '{32'h0000_0041, 9, 1'b1, 32'd3, 32'd6};
    vt[9]  = '{32'h0000_0042, 0, 1'b0, 32'd3, 32'd7};
    vt[10] = '{32'h0000_0150, 4, 1'b0, 32'd3, 32'd8};
    vt[11] = '{32'h0000_0150, 0, 1'b0, 32'd3, 32'd9};

    // Reset with a request pending: outputs must still read zero.
    rst_n    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0023;
    flush    = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(cpu_valid), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_inst", cpu_inst, 32'd0);
    chk("rst_ptr", mem_ptr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      fetch(vt[i].addr, vt[i].fsel, vt[i].hit);
      @(negedge clk);
      chk("vec_hits", hit_count, vt[i].hits);
      chk("vec_misses", miss_count, vt[i].misses);
      @(posedge clk); #1;
    end

    // Async reset in the first FILL cycle, between clock edges.
    fetch(32'h0000_0040, 0, m_hit(32'h0000_0040));
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0300;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(cpu_stall), 32'd0);
    chk("arst_valid", 32'(cpu_valid), 32'd0);
    chk("arst_inst", cpu_inst, 32'd0);
    chk("arst_ptr", mem_ptr, 32'd0);
    chk("arst_hits", hit_count, 32'd0);
    chk("arst_misses", miss_count, 32'd0);
    cpu_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(32'h0000_0040, 0, 1'b0);
    chk_counts("post_arst");
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int          r, fsel;
      bit          h;
      a    = 32'($urandom_range(0, 1023));
      r    = int'($urandom_range(0, 15));
      fsel = (r == 11) ? 9 : ((r >= 12) ? r - 11 : 0);
      h    = m_hit(a);
      if (h && fsel != 9) fsel = 0;
      fetch(a, fsel, h);
      chk_counts("rnd");
      @(posedge clk); #1;
    end

    // Saturation of the hit counter.
    fetch(32'h0000_0040, 0, m_hit(32'h0000_0040));
    @(negedge clk);
    force dut.hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt;
    m_hits = 32'hFFFF_FFFE;
    chk("sat_preset", hit_count, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) fetch(32'h0000_0040, 0, 1'b1);
    @(negedge clk);
    chk("sat_hits", hit_count, 32'hFFFF_FFFF);
    chk("sat_model", hit_count, m_hits);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
